// File: rtl/demux_pkg.sv
// Slot encodings shared by the 1-to-5 demux and the 5-to-1 select mux.
package demux_pkg;

    localparam int NUM_SLOTS = 5;
    localparam int SEL_W     = 3;

    localparam logic [SEL_W-1:0] SLOT_A = 3'd0;
    localparam logic [SEL_W-1:0] SLOT_B = 3'd1;
    localparam logic [SEL_W-1:0] SLOT_C = 3'd2;
    localparam logic [SEL_W-1:0] SLOT_D = 3'd3;
    localparam logic [SEL_W-1:0] SLOT_E = 3'd4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // One-hot decode of a select; illegal selects (>= NUM_SLOTS) decode to all zeros.
    function automatic logic [NUM_SLOTS-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_SLOTS-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (sel == SEL_W'(k)) begin
                oh[k] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/slot_reg.sv
// One destination slot: EMPTY/FULL state flop plus the held data word.
// Handshake: load is only raised for an accepted write (slot empty or acked this cycle).
module slot_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    slot_state_t state;
    slot_state_t state_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= EMPTY;
            dout  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                dout <= din;
            end
        end
    end

    // A load wins over an ack in the same cycle, so the slot stays FULL with new data.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = FULL;
        end else if (ack) begin
            state_nxt = EMPTY;
        end
    end

    assign valid = (state == FULL);

endmodule

// File: rtl/demux1b5_reg.sv
// Registered 1-to-5 demux: steers I into slot S, each slot held until its consumer acks.
// Handshake: a write is accepted when WE & READY; READY = !V[S] | ACK[S] for legal S, else 1.
module demux1b5_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     I,
    input  logic [SEL_W-1:0]     S,
    input  logic                 WE,
    output logic                 READY,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     C,
    output logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     E,
    output logic                 VA,
    output logic                 VB,
    output logic                 VC,
    output logic                 VD,
    output logic                 VE,
    input  logic [NUM_SLOTS-1:0] ACK,
    output logic                 ERR
);

    logic [NUM_SLOTS-1:0] sel_oh;
    logic [NUM_SLOTS-1:0] valid;
    logic [NUM_SLOTS-1:0] load;
    logic [WIDTH-1:0]     slot_data [NUM_SLOTS];
    logic                 sel_legal;
    logic                 accept;

    assign sel_oh    = sel_decode(S);
    assign sel_legal = |sel_oh;

    // Illegal selects are always accepted so the producer never stalls on them.
    assign READY  = !sel_legal || (|(sel_oh & (~valid | ACK)));
    assign accept = WE && READY;
    assign load   = accept ? sel_oh : '0;

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        slot_reg #(.WIDTH(WIDTH)) u_slot (
            .CLK   (CLK),
            .RST   (RST),
            .load  (load[k]),
            .ack   (ACK[k]),
            .din   (I),
            .dout  (slot_data[k]),
            .valid (valid[k])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR <= 1'b0;
        end else if (accept && !sel_legal) begin
            ERR <= 1'b1;
        end
    end

    assign A  = slot_data[SLOT_A];
    assign B  = slot_data[SLOT_B];
    assign C  = slot_data[SLOT_C];
    assign D  = slot_data[SLOT_D];
    assign E  = slot_data[SLOT_E];
    assign VA = valid[SLOT_A];
    assign VB = valid[SLOT_B];
    assign VC = valid[SLOT_C];
    assign VD = valid[SLOT_D];
    assign VE = valid[SLOT_E];

endmodule

// File: doc/demux1b5_reg.md
# demux1b5_reg

Registered 1-to-5 demultiplexer with per-destination valid/acknowledge handshake. It is the write-side counterpart of the 5-to-1 select mux: the mux picks one of five sources onto one line, and this block steers one source word into one of five destination slots, numbered A–E. Each slot holds its word until the consumer on that slot acknowledges it. It sits between the datapath result bus and the five downstream holding registers in the processor.

## Interface
Parameters:
- WIDTH, 16, data word width for I and A–E.

Ports:
- CLK, input, 1, single system clock; all state updates on the rising edge.
- RST, input, 1, asynchronous, active-high reset.
- I, input, WIDTH, data word to steer.
- S, input, 3, destination select: 0=A, 1=B, 2=C, 3=D, 4=E; 5–7 are illegal.
- WE, input, 1, write request, qualified by READY.
- READY, output, 1, combinational: the current write request is accepted this cycle.
- A, B, C, D, E, output, WIDTH each, slot data registers.
- VA, VB, VC, VD, VE, output, 1 each, slot valid flags.
- ACK, input, 5, per-slot consumer acknowledge; bit 0 = A … bit 4 = E.
- ERR, output, 1, sticky illegal-select flag.

## Operation
- Each slot is a two-state machine:
  - EMPTY (valid = 0).
  - FULL (valid = 1).
- Slot transitions:
  - EMPTY → FULL on an accepted write to that slot.
  - FULL → EMPTY on ACK[k] with no accepted write to that slot in the same cycle.
  - FULL → FULL, with data replaced, on ACK[k] and an accepted write to that slot in the same cycle.
- READY rules:
  - For S ≤ 4: READY = !V[S] | ACK[S]. A full slot being acknowledged this cycle accepts a new word, giving back-to-back throughput of one word per cycle per slot.
  - For S ≥ 5: READY = 1. The word is accepted and discarded.
- An accepted write (WE & READY) with S ≤ 4 loads I into slot S and sets V[S].
- An accepted write with S ≥ 5 sets ERR. No slot data or valid flag changes.
- ERR is sticky and is cleared only by RST.
- WE while READY = 0 has no effect. The producer must hold I, S and WE until READY = 1.
- ACK[k] while V[k] = 0 is ignored and does not set ERR.
- Slot data is unchanged on ACK-only cycles. Only valid is cleared; the data output keeps its last value.
- Multiple ACK bits may be asserted in one cycle, and each slot responds independently.
- Only one write occurs per cycle. Slots other than S are affected only by their own ACK bit.

## Timing
- Reset state, asynchronous and immediate on RST high:
  - A–E = 0.
  - VA–VE = 0.
  - ERR = 0.
  - READY then evaluates combinationally to 1 for any S.
- RST asserted mid-operation discards all held words and pending valids. A write presented in the same cycle that RST deasserts is accepted on the next rising edge, as normal.
- Write latency: data and valid are visible one cycle after the accepting edge. Data written on edge n appears on the slot output after edge n.
- ACK latency: the valid flag drops after the edge on which ACK is sampled.
- READY has a combinational path from S, WE-independent state, and ACK. There is no combinational path from I to any output.
- ERR rises after the edge that accepts the illegal write.

## Structure
- Shared package `demux_pkg` holds:
  - slot index constants SLOT_A=0 through SLOT_E=4.
  - NUM_SLOTS=5.
  - SEL_W=3.
  - The package is shared with the 5-to-1 mux so both ends use identical encodings.
- One natural sub-module, `slot_reg`, instantiated five times:
  - Inputs: CLK, RST, load, ack, din.
  - Outputs: dout, valid.
  - Contains the EMPTY/FULL flop and the WIDTH-bit data register.
- Top level contains:
  - 3-to-5 one-hot select decode.
  - READY mux.
  - illegal-select detect.
  - ERR flop.

## Test plan
- Reset, then WE=1, S=2, I=16'h00A5 for one cycle → READY=1; after the edge C=16'h00A5, VC=1; all other valids 0; ERR=0.
- Slot C full, WE=1, S=2, I=16'h1234, ACK=0 → READY=0 and C stays 16'h00A5. Raise ACK[2] with the same request → READY=1; after the edge C=16'h1234, VC=1 (simultaneous write and ACK).
- Fill A–E with 16'h0001–16'h0005, then ACK=5'b10101 → after one edge VA=VC=VE=0, VB=VD=1, and data outputs unchanged.
- WE=1, S=6, I=16'hFFFF → READY=1; after the edge ERR=1 and all slots unchanged. Subsequent legal writes proceed normally, and ERR stays 1 until RST.
- Slots B and D full, assert RST asynchronously between edges → all outputs 0 immediately, before the next CLK edge.
- ACK=5'b11111 with all slots empty → no state change and ERR=0. Then 8 back-to-back writes to S=4 with ACK[4] held high → E tracks each word, one per cycle, and VE stays 1.
